// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier, multiplies skip the CALC phase.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                is_div_q, is_div_d;
  logic                neg_lo_q, neg_lo_d;
  logic                neg_hi_q, neg_hi_d;
  logic                sel_hi_q, sel_hi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                op_div_s;
  logic                a_signed_s, b_signed_s;
  logic                a_neg_s, b_neg_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s;
  logic                div_zero_s, div_ovf_s;
  logic [XLEN-1:0]     spec_res_s;
  logic                accept_s;

  logic [XLEN:0]       mul_sum_s;
  logic [XLEN:0]       div_shift_s, div_diff_s;
  logic                div_ge_s;
  logic [2*XLEN-1:0]   step_s;

  logic [2*XLEN-1:0]   prod_fix_s;
  logic [XLEN-1:0]     quo_fix_s, rem_fix_s;
  logic [XLEN-1:0]     fin_res_s;

  // Operand decode: signedness per funct3, magnitudes and the division special cases.
  always_comb begin
    op_div_s   = funct3[2];
    a_signed_s = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed_s = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg_s    = a_signed_s & op_a[XLEN-1];
    b_neg_s    = b_signed_s & op_b[XLEN-1];
    a_mag_s    = a_neg_s ? -op_a : op_a;
    b_mag_s    = b_neg_s ? -op_b : op_b;
    div_zero_s = op_div_s && (op_b == {XLEN{1'b0}});
    div_ovf_s  = op_div_s && !funct3[0]
                 && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                 && (op_b == {XLEN{1'b1}});
    if (div_zero_s) begin
      spec_res_s = funct3[1] ? op_a : {XLEN{1'b1}};
    end else begin
      spec_res_s = funct3[1] ? {XLEN{1'b0}} : op_a;
    end
    accept_s = (state_q == S_IDLE) && start && !flush && !done_q;
  end

  // One radix-2 iteration; acc holds {partial product, multiplier} or {remainder, dividend}.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, b_q};
    div_ge_s    = ~div_diff_s[XLEN];
    if (is_div_q) begin
      step_s = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0]),
                acc_q[XLEN-2:0], div_ge_s};
    end else begin
      step_s = {mul_sum_s, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction: a product is negated as a whole, quotient and remainder separately.
  always_comb begin
    prod_fix_s = neg_lo_q ? -acc_q : acc_q;
    quo_fix_s  = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix_s  = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (is_div_q) begin
      fin_res_s = sel_hi_q ? rem_fix_s : quo_fix_s;
    end else begin
      fin_res_s = sel_hi_q ? prod_fix_s[2*XLEN-1:XLEN] : prod_fix_s[XLEN-1:0];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    sel_hi_d = sel_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        busy_d = accept_s;
        if (accept_s) begin
          cnt_d    = CNT_W'(XLEN-1);
          is_div_d = op_div_s;
          if (div_zero_s || div_ovf_s) begin
            acc_d    = {{XLEN{1'b0}}, spec_res_s};
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            sel_hi_d = 1'b0;
            state_d  = S_FIN;
          end else if (op_div_s) begin
            acc_d    = {{XLEN{1'b0}}, a_mag_s};
            b_d      = b_mag_s;
            neg_lo_d = a_neg_s ^ b_neg_s;
            neg_hi_d = a_neg_s;
            sel_hi_d = funct3[1];
            state_d  = S_CALC;
          end else begin
            neg_lo_d = a_neg_s ^ b_neg_s;
            neg_hi_d = a_neg_s ^ b_neg_s;
            sel_hi_d = (funct3[1:0] != 2'b00);
`ifdef MULDIV_FAST_MUL_EN
            acc_d    = (2*XLEN)'(a_mag_s) * (2*XLEN)'(b_mag_s);
            state_d  = S_FIN;
`else
            acc_d    = {{XLEN{1'b0}}, b_mag_s};
            b_d      = a_mag_s;
            state_d  = S_CALC;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = step_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == {CNT_W{1'b0}}) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_FIN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIN: begin
        result_d = fin_res_s;
        done_d   = 1'b1;
        busy_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // Abort never produces a done pulse and leaves the last result untouched.
    if (flush) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end else begin
      busy_d = busy_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      b_q      <= {XLEN{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      sel_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      sel_hi_q <= sel_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN = 32): vector table plus corner sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 2;
`else
  localparam int MLAT = 34;
`endif
  localparam int DLAT = 34;
  localparam int SLAT = 2;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after acceptance) of done, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    launch(f, a, b);
    wait_done(lat);
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " result"}, result, exp);
    check({nm, " busy in done cycle"}, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int lat;
    int done_seen;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MLAT};
    vecs[2]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MLAT};
    vecs[3]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, MLAT};
    vecs[4]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT};
    vecs[5]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MLAT};
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DLAT};
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DLAT};
    vecs[8]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, DLAT};
    vecs[9]  = '{3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, SLAT};
    vecs[10] = '{3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, SLAT};
    vecs[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SLAT};
    vecs[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SLAT};
    vecs[13] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, DLAT};
    vecs[14] = '{3'b100, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, DLAT};
    vecs[15] = '{3'b110, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, DLAT};
    vecs[16] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DLAT};
    vecs[17] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DLAT};

    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    op_a   = 32'd0;
    op_b   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // start raised during the done cycle must not be accepted
    @(negedge clk);
    run_op("pre-donecycle DIVU", 3'b101, 32'h0000_0064, 32'h0000_000A, 32'h0000_000A, DLAT);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'h0000_0005;
    op_b   = 32'h0000_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("donecycle start busy", {31'd0, busy}, 32'd0);
    check("donecycle start done", {31'd0, done}, 32'd0);
    check("donecycle start result", result, 32'h0000_000A);

    // flush at iteration 10 of a DIV
    launch(3'b100, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush result held", result, 32'h0000_000A);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("flush no done", done_seen, 32'd0);
    run_op("post-flush DIV", 3'b100, 32'd1000, 32'd3, 32'd333, DLAT);

    // flush and start in the same idle cycle: flush wins
    @(negedge clk);
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'b100;
    op_a   = 32'd50;
    op_b   = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush+start busy", {31'd0, busy}, 32'd0);
    check("flush+start done", {31'd0, done}, 32'd0);

    // start while busy with different operands is ignored
    launch(3'b100, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b011;
    op_a   = 32'hFFFF_FFFF;
    op_b   = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("busy-start latency", lat, 32'd29);
    check("busy-start result", result, 32'd142);
    @(negedge clk);
    check("busy-start no reaccept", {31'd0, busy}, 32'd0);

    // synchronous reset in the middle of CALC
    launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midcalc rst busy", {31'd0, busy}, 32'd0);
    check("midcalc rst done", {31'd0, done}, 32'd0);
    check("midcalc rst result", result, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("midcalc rst no done", done_seen, 32'd0);
    run_op("post-rst MUL", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
